snake_mover: RTL and testbench



---
 rtl/snake_mover.sv | 186 ++++++++++++++++++
 tb/tb_snake_mover.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_mover.sv
// snake_mover: advances the snake one cell per accepted move_tick (move, grow or collide),
// owns the body segment store and answers registered per-pixel body/head queries.
module snake_mover #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int MAX_LEN = 16,
  parameter int CW      = 4,
  parameter int LW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          move_tick,
  input  logic [2:0]    direction,
  input  logic [1:0]    game_state,
  input  logic [CW-1:0] food_x,
  input  logic [CW-1:0] food_y,
  input  logic [CW-1:0] pix_x,
  input  logic [CW-1:0] pix_y,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          busy,
  output logic          food_eaten,
  output logic          collision,
  output logic          seg_hit,
  output logic          head_hit,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, CHECK = 2'd2, COMMIT = 2'd3} state_t;

  localparam logic [CW-1:0] X0    = CW'(GRID_W / 2);
  localparam logic [CW-1:0] Y0    = CW'(GRID_H / 2);
  localparam logic [CW-1:0] XMAX  = CW'(GRID_W - 1);
  localparam logic [CW-1:0] YMAX  = CW'(GRID_H - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [LW-1:0] L_ONE = LW'(1);
  localparam logic [LW-1:0] LEN0  = LW'(3);
  localparam logic [LW-1:0] LMAX  = LW'(MAX_LEN);

  state_t        state_q, state_d;
  logic [CW-1:0] seg_x [MAX_LEN];
  logic [CW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len_q, lim_q, idx_q, lim_c;
  logic [CW-1:0] nx_q, ny_q, nx_c, ny_c, cur_x, cur_y;
  logic [2:0]    dir_q;
  logic          grow_q, hit_q, wall_c, grow_c, cur_match, last_c, start, clear, any_hit_c;

  // Handshake: move_tick is a request with no ready; it is accepted only in IDLE,
  // and while busy is high further ticks are dropped rather than queued.
  assign clear = (game_state == 2'b00);
  assign start = move_tick && (game_state == 2'b01) &&
                 (direction >= 3'd1) && (direction <= 3'd4);

  // Candidate head and wall/food tests, consumed in CALC.
  always_comb begin
    nx_c   = seg_x[0];
    ny_c   = seg_y[0];
    wall_c = 1'b0;
    case (dir_q)
      3'd1: begin ny_c = seg_y[0] - C_ONE; wall_c = (seg_y[0] == '0);  end
      3'd2: begin ny_c = seg_y[0] + C_ONE; wall_c = (seg_y[0] == YMAX); end
      3'd3: begin nx_c = seg_x[0] - C_ONE; wall_c = (seg_x[0] == '0);  end
      3'd4: begin nx_c = seg_x[0] + C_ONE; wall_c = (seg_x[0] == XMAX); end
      default: ;
    endcase
    grow_c = (nx_c == food_x) && (ny_c == food_y);
    // The tail vacates on a plain move, so it is only searched when growing.
    lim_c  = grow_c ? len_q : len_q - L_ONE;
  end

  always_comb begin
    cur_x = seg_x[0];
    cur_y = seg_y[0];
    for (int k = 0; k < MAX_LEN; k++) begin
      if (idx_q == LW'(k)) begin
        cur_x = seg_x[k];
        cur_y = seg_y[k];
      end
    end
  end

  assign cur_match = (cur_x == nx_q) && (cur_y == ny_q);
  assign last_c    = (idx_q == lim_q - L_ONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    state_d = wall_c ? COMMIT : CHECK;
      CHECK:   if (cur_match || last_c) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= '0;
        seg_y[k] <= '0;
      end
      seg_x[0]   <= X0;
      seg_y[0]   <= Y0;
      seg_x[1]   <= X0 - C_ONE;
      seg_y[1]   <= Y0;
      seg_x[2]   <= X0 - CW'(2);
      seg_y[2]   <= Y0;
      len_q      <= LEN0;
      food_eaten <= 1'b0;
      collision  <= 1'b0;
      dir_q      <= '0;
      nx_q       <= '0;
      ny_q       <= '0;
      lim_q      <= '0;
      idx_q      <= '0;
      grow_q     <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      food_eaten <= 1'b0;
      collision  <= 1'b0;
      case (state_q)
        IDLE: if (start) dir_q <= direction;
        CALC: begin
          nx_q   <= nx_c;
          ny_q   <= ny_c;
          grow_q <= grow_c;
          lim_q  <= lim_c;
          hit_q  <= wall_c;
          idx_q  <= '0;
        end
        CHECK: begin
          if (cur_match)    hit_q <= 1'b1;
          else if (!last_c) idx_q <= idx_q + L_ONE;
        end
        COMMIT: begin
          if (hit_q) begin
            collision <= 1'b1;
          end else begin
            for (int k = MAX_LEN - 1; k > 0; k--) begin
              seg_x[k] <= seg_x[k-1];
              seg_y[k] <= seg_y[k-1];
            end
            seg_x[0] <= nx_q;
            seg_y[0] <= ny_q;
            if (grow_q) begin
              food_eaten <= 1'b1;
              if (len_q != LMAX) len_q <= len_q + L_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    any_hit_c = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((LW'(k) < len_q) && (seg_x[k] == pix_x) && (seg_y[k] == pix_y)) any_hit_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_hit  <= 1'b0;
      head_hit <= 1'b0;
    end else begin
      seg_hit  <= any_hit_c;
      head_hit <= (seg_x[0] == pix_x) && (seg_y[0] == pix_y);
    end
  end

  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign length    = len_q;
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_snake_mover.sv
// Bench for snake_mover: directed vector table, hand sequences for corner cases,
// and randomized steps checked against a queue-based model of the snake.
module tb_snake_mover;
  localparam int GRID_W = 16, GRID_H = 12, MAX_LEN = 16, CW = 4, LW = 5, W = 32;

  logic          clk = 1'b0;
  logic          reset, move_tick;
  logic [2:0]    direction;
  logic [1:0]    game_state;
  logic [CW-1:0] food_x, food_y, pix_x, pix_y, head_x, head_y;
  logic [LW-1:0] length;
  logic          busy, food_eaten, collision, seg_hit, head_hit;
  logic [1:0]    fsm_state;

  snake_mover #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN), .CW(CW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .move_tick(move_tick), .direction(direction),
    .game_state(game_state), .food_x(food_x), .food_y(food_y), .pix_x(pix_x), .pix_y(pix_y),
    .head_x(head_x), .head_y(head_y), .length(length), .busy(busy),
    .food_eaten(food_eaten), .collision(collision), .seg_hit(seg_hit), .head_hit(head_hit),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_lat, obs_fe, obs_co;
  int mx[$];
  int my[$];
  logic [W-1:0] exp_q[$];

  typedef struct {
    int d; int fx; int fy;
    int lat; int fe; int co; int hx; int hy; int len;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int lat, input int fe, input int co,
                                        input int hx, input int hy, input int len);
    return {8'(lat), 8'(hx), 8'(hy), 6'(len), 1'(fe), 1'(co)};
  endfunction

  function automatic void model_reset();
    mx = '{GRID_W/2, GRID_W/2 - 1, GRID_W/2 - 2};
    my = '{GRID_H/2, GRID_H/2, GRID_H/2};
  endfunction

  // Snake as a queue of cells, head first; latency counted in edges after the tick edge.
  function automatic logic [W-1:0] model_step(input int d, input int fx, input int fy);
    int nx, ny, lim, lat;
    bit wall, grow, hit;
    nx = mx[0];
    ny = my[0];
    case (d)
      1: ny = ny - 1;
      2: ny = ny + 1;
      3: nx = nx - 1;
      default: nx = nx + 1;
    endcase
    wall = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
    grow = (nx == fx) && (ny == fy);
    hit  = wall;
    lat  = 2;
    if (!wall) begin
      lim = grow ? mx.size() : mx.size() - 1;
      lat = lim + 2;
      for (int i = 0; i < lim; i++) begin
        if (mx[i] == nx && my[i] == ny) begin
          hit = 1'b1;
          lat = i + 3;
          break;
        end
      end
    end
    if (!hit) begin
      mx.push_front(nx);
      my.push_front(ny);
      if (!grow || mx.size() > MAX_LEN) begin
        void'(mx.pop_back());
        void'(my.pop_back());
      end
    end
    return pack(lat, int'(!hit && grow), int'(hit), mx[0], my[0], mx.size());
  endfunction

  // All driver tasks start and end just after a falling edge.
  task automatic run_step(input int d, input int fx, input int fy, input bit retick);
    int n, fe_n, co_n;
    logic [W-1:0] e;
    n = 0; fe_n = 0; co_n = 0;
    food_x = CW'(fx);
    food_y = CW'(fy);
    direction = 3'(d);
    move_tick = 1'b1;
    exp_q.push_back(model_step(d, fx, fy));
    @(posedge clk);
    @(negedge clk);
    move_tick = 1'b0;
    check("busy_after_tick", busy, 1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      fe_n += food_eaten;
      co_n += collision;
      if (retick && k == 1) begin
        move_tick = 1'b1;
        direction = 3'd1;
      end else begin
        move_tick = 1'b0;
      end
      if (!busy) begin
        n = k;
        break;
      end
    end
    if (n == 0) check("step_busy_cleared", busy, 0);
    move_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    fe_n += food_eaten;
    co_n += collision;
    check("no_retrigger_busy", busy, 0);
    e = exp_q.pop_front();
    obs_lat = n; obs_fe = fe_n; obs_co = co_n;
    check("step_latency", n, int'(e[31:24]));
    check("food_eaten_pulses", fe_n, int'(e[1]));
    check("collision_pulses", co_n, int'(e[0]));
    check("head_x", head_x, int'(e[23:16]));
    check("head_y", head_y, int'(e[15:8]));
    check("length", length, int'(e[7:2]));
  endtask

  task automatic drop_tick(input int d, input int gs);
    direction = 3'(d);
    game_state = 2'(gs);
    move_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    move_tick = 1'b0;
    game_state = 2'b01;
    check("drop_busy", busy, 0);
    check("drop_fsm_idle", fsm_state, 0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("drop_busy_later", busy, 0);
    check("drop_head_x", head_x, mx[0]);
    check("drop_head_y", head_y, my[0]);
    check("drop_length", length, mx.size());
  endtask

  task automatic query(input int x, input int y);
    int exp_seg;
    exp_seg = 0;
    for (int i = 0; i < mx.size(); i++) if (mx[i] == x && my[i] == y) exp_seg = 1;
    pix_x = CW'(x);
    pix_y = CW'(y);
    @(posedge clk);
    @(negedge clk);
    check("seg_hit", seg_hit, exp_seg);
    check("head_hit", head_hit, int'(mx[0] == x && my[0] == y));
  endtask

  task automatic query_body();
    for (int i = 0; i < mx.size(); i++) query(mx[i], my[i]);
  endtask

  task automatic layout_reset();
    game_state = 2'b00;
    @(posedge clk);
    @(negedge clk);
    game_state = 2'b01;
    model_reset();
  endtask

  // Food placed on the cell ahead, or a random cell when ahead is off-grid.
  task automatic step_to_food(input int d);
    int fx, fy;
    fx = mx[0] + ((d == 4) ? 1 : (d == 3) ? -1 : 0);
    fy = my[0] + ((d == 2) ? 1 : (d == 1) ? -1 : 0);
    if (fx < 0 || fx >= GRID_W || fy < 0 || fy >= GRID_H) begin
      fx = $urandom_range(0, GRID_W - 1);
      fy = $urandom_range(0, GRID_H - 1);
    end
    run_step(d, fx, fy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{d:4, fx:0,  fy:0, lat:4, fe:0, co:0, hx:9,  hy:6, len:3};
    tbl[1] = '{d:4, fx:10, fy:6, lat:5, fe:1, co:0, hx:10, hy:6, len:4};
    tbl[2] = '{d:1, fx:0,  fy:0, lat:5, fe:0, co:0, hx:10, hy:5, len:4};
    tbl[3] = '{d:3, fx:0,  fy:0, lat:5, fe:0, co:0, hx:9,  hy:5, len:4};
    tbl[4] = '{d:2, fx:0,  fy:0, lat:5, fe:0, co:0, hx:9,  hy:6, len:4};
    tbl[5] = '{d:4, fx:10, fy:6, lat:6, fe:0, co:1, hx:9,  hy:6, len:4};
    tbl[6] = '{d:1, fx:0,  fy:0, lat:4, fe:0, co:1, hx:9,  hy:6, len:4};

    // Clock/reset
    reset = 1'b1; move_tick = 1'b0; direction = 3'd0; game_state = 2'b00;
    food_x = '0; food_y = '0; pix_x = '0; pix_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_head_x", head_x, 8);
    check("rst_head_y", head_y, 6);
    check("rst_length", length, 3);
    check("rst_busy", busy, 0);
    check("rst_food_eaten", food_eaten, 0);
    check("rst_collision", collision, 0);
    check("rst_seg_hit", seg_hit, 0);
    check("rst_head_hit", head_hit, 0);
    reset = 1'b0;
    game_state = 2'b01;
    model_reset();
    query(8, 6);
    query(6, 6);
    query(5, 6);

    // Directed table: move, grow, tail-vacate, tail-with-food, early body hit
    for (int i = 0; i < 7; i++) begin
      run_step(tbl[i].d, tbl[i].fx, tbl[i].fy, 1'b0);
      check("tbl_latency", obs_lat, tbl[i].lat);
      check("tbl_food_eaten", obs_fe, tbl[i].fe);
      check("tbl_collision", obs_co, tbl[i].co);
      check("tbl_head_x", head_x, tbl[i].hx);
      check("tbl_head_y", head_y, tbl[i].hy);
      check("tbl_length", length, tbl[i].len);
      query_body();
    end

    // Wall on the right edge, with a tick during busy that must be ignored
    layout_reset();
    for (int i = 0; i < 7; i++) run_step(4, 0, 0, 1'b1);
    check("at_edge_head_x", head_x, 15);
    run_step(4, 0, 0, 1'b1);
    check("wall_latency", obs_lat, 2);
    check("wall_collision", obs_co, 1);
    check("wall_head_x", head_x, 15);
    check("wall_length", length, 3);

    drop_tick(0, 1);
    drop_tick(5, 1);
    drop_tick(3, 2);
    drop_tick(3, 3);

    // Grow to the store depth, then eat once more
    layout_reset();
    for (int i = 0; i < 7; i++) step_to_food(4);
    step_to_food(2);
    for (int i = 0; i < 7; i++) step_to_food(3);
    check("max_length", length, MAX_LEN);
    check("max_food_eaten", obs_fe, 1);
    query_body();

    // Abort mid-CHECK through game_state START
    direction = 3'd1;
    food_x = '0; food_y = '0;
    move_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    move_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_check", fsm_state, 2);
    game_state = 2'b00;
    @(posedge clk);
    @(negedge clk);
    game_state = 2'b01;
    model_reset();
    check("abort_busy", busy, 0);
    check("abort_head_x", head_x, 8);
    check("abort_head_y", head_y, 6);
    check("abort_length", length, 3);
    query(7, 6);
    query(9, 7);

    // Randomized steps against the model
    for (int n = 0; n < 120; n++) begin
      int d, gs;
      d  = $urandom_range(0, 7);
      gs = ($urandom_range(0, 9) == 0) ? 2 : 1;
      if (gs != 1 || d == 0 || d > 4) begin
        drop_tick(d, gs);
      end else if ($urandom_range(0, 1) == 1) begin
        step_to_food(d);
      end else begin
        run_step(d, $urandom_range(0, GRID_W - 1), $urandom_range(0, GRID_H - 1), 1'b0);
      end
      query(mx[0], my[0]);
      query($urandom_range(0, GRID_W - 1), $urandom_range(0, GRID_H - 1));
      if (mx.size() > 1) query(mx[mx.size() - 1], my[my.size() - 1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
